// File: rtl/hz_countdown_timer.sv
// MM:SS BCD countdown timer driven by the Hz divider square wave.
// Offers load/start/pause control, a one-clock done pulse and an alarm window.
module hz_countdown_timer #(
    parameter int SYNC_STAGES = 2,
    parameter int ALARM_SECS  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hz_in,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       done,
    output logic       alarm
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_ALARM
    } state_e;

    localparam logic [3:0] ALARM_LAST = 4'(ALARM_SECS - 1);

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   tick;
    logic [7:0]             min_q, min_d;
    logic [7:0]             sec_q, sec_d;
    logic [3:0]             acnt_q, acnt_d;
    logic                   done_q, done_d;
    logic                   run_q, alarm_q;
    logic [15:0]            ld_t, dec_t;
    logic                   time_zero;

    function automatic logic [3:0] sat(input logic [3:0] d,
                                       input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    assign tick      = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign ld_t      = {sat(load_min[7:4], 4'd9), sat(load_min[3:0], 4'd9),
                        sat(load_sec[7:4], 4'd5), sat(load_sec[3:0], 4'd9)};
    assign dec_t     = bcd_dec({min_q, sec_q});
    assign time_zero = ({min_q, sec_q} == 16'h0000);

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        acnt_d  = acnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (load) begin
                    {min_d, sec_d} = ld_t;
                end else if (start && !time_zero) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Expiry outranks a pause landing on the final tick.
                if (tick) begin
                    {min_d, sec_d} = dec_t;
                    if (dec_t == 16'h0000) begin
                        done_d  = 1'b1;
                        acnt_d  = 4'd0;
                        state_d = S_ALARM;
                    end else if (pause) begin
                        state_d = S_PAUSE;
                    end
                end else if (pause) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (load) begin
                    {min_d, sec_d} = ld_t;
                    state_d        = S_IDLE;
                end else if (start) begin
                    state_d = S_RUN;
                end
            end
            S_ALARM: begin
                if (load) begin
                    {min_d, sec_d} = ld_t;
                    state_d        = S_IDLE;
                end else if (tick) begin
                    if (acnt_q == ALARM_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        acnt_d = acnt_q + 4'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sync_q  <= '0;
            prev_q  <= 1'b0;
            min_q   <= 8'h00;
            sec_q   <= 8'h00;
            acnt_q  <= 4'd0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], hz_in};
            prev_q  <= sync_q[SYNC_STAGES-1];
            min_q   <= min_d;
            sec_q   <= sec_d;
            acnt_q  <= acnt_d;
            done_q  <= done_d;
            run_q   <= (state_d == S_RUN);
            alarm_q <= (state_d == S_ALARM);
        end
    end

    assign min_bcd = min_q;
    assign sec_bcd = sec_q;
    assign running = run_q;
    assign done    = done_q;
    assign alarm   = alarm_q;
endmodule

// File: tb/tb_hz_countdown_timer.sv
// Bench for hz_countdown_timer: directed scenarios plus random traffic
// compared against a seconds-based reference model.
module tb_hz_countdown_timer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       hz_in = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_min = 8'h00;
    logic [7:0] load_sec = 8'h00;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] min_bcd, sec_bcd;
    logic       running, done, alarm;
    logic [18:0] obs;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    localparam int ST_IDLE  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_PAUSE = 2;
    localparam int ST_ALARM = 3;
    localparam int ALARM_N  = 5;

    int   m_state;
    int   m_secs;
    int   m_left;
    bit   m_done;
    bit   m_last_hz;
    int   tick_q[$];

    hz_countdown_timer #(.SYNC_STAGES(2), .ALARM_SECS(ALARM_N)) dut (
        .clk     (clk),
        .reset   (reset),
        .hz_in   (hz_in),
        .load    (load),
        .load_min(load_min),
        .load_sec(load_sec),
        .start   (start),
        .pause   (pause),
        .min_bcd (min_bcd),
        .sec_bcd (sec_bcd),
        .running (running),
        .done    (done),
        .alarm   (alarm)
    );

    always #5 clk = ~clk;

    assign obs = {min_bcd, sec_bcd, running, done, alarm};

    function automatic int load_secs(input logic [7:0] lm,
                                     input logic [7:0] ls);
        int mt = int'(lm[7:4]);
        int mo = int'(lm[3:0]);
        int st = int'(ls[7:4]);
        int so = int'(ls[3:0]);
        if (mt > 9) mt = 9;
        if (mo > 9) mo = 9;
        if (st > 5) st = 5;
        if (so > 9) so = 9;
        return (mt * 10 + mo) * 60 + st * 10 + so;
    endfunction

    function automatic logic [18:0] exp_vec();
        int m = m_secs / 60;
        int s = m_secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                m_state == ST_RUN, m_done, m_state == ST_ALARM};
    endfunction

    task automatic model_reset();
        m_state   = ST_IDLE;
        m_secs    = 0;
        m_left    = 0;
        m_done    = 0;
        m_last_hz = 0;
        tick_q.delete();
    endtask

    // A rising hz sample is consumed as a second two edges later.
    task automatic model_edge(input bit ld, input logic [7:0] lm,
                              input logic [7:0] ls, input bit st,
                              input bit pa, input bit hz);
        bit tk = 0;
        if (tick_q.size() > 0 && tick_q[0] == cyc) begin
            tk = 1;
            void'(tick_q.pop_front());
        end
        if (hz && !m_last_hz) tick_q.push_back(cyc + 2);
        m_last_hz = hz;
        m_done = 0;
        case (m_state)
            ST_IDLE: begin
                if (ld) m_secs = load_secs(lm, ls);
                else if (st && m_secs != 0) m_state = ST_RUN;
            end
            ST_RUN: begin
                if (tk) begin
                    m_secs--;
                    if (m_secs == 0) begin
                        m_done  = 1;
                        m_state = ST_ALARM;
                        m_left  = ALARM_N;
                    end else if (pa) begin
                        m_state = ST_PAUSE;
                    end
                end else if (pa) begin
                    m_state = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (ld) begin
                    m_secs  = load_secs(lm, ls);
                    m_state = ST_IDLE;
                end else if (st) begin
                    m_state = ST_RUN;
                end
            end
            default: begin
                if (ld) begin
                    m_secs  = load_secs(lm, ls);
                    m_state = ST_IDLE;
                end else if (tk) begin
                    m_left--;
                    if (m_left == 0) m_state = ST_IDLE;
                end
            end
        endcase
    endtask

    task automatic step(input bit ld, input logic [7:0] lm,
                        input logic [7:0] ls, input bit st,
                        input bit pa, input bit hz);
        load     = ld;
        load_min = lm;
        load_sec = ls;
        start    = st;
        pause    = pa;
        hz_in    = hz;
        @(posedge clk);
        cyc++;
        if (!reset) model_reset();
        else model_edge(ld, lm, ls, st, pa, hz);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 8'h00, 0, 0, i[0]);
            checks++;
            if (obs !== 19'd0) begin
                errors++;
                $display("FAIL reset_hold got=%h exp=%h", obs, 19'd0);
            end
        end
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(0, 8'h00, 8'h00, 0, 0, (i % 4) < 2);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h",
                         cyc, obs, exp_vec());
            end
        end
    endtask

    task automatic test_basic();
        int  dones = 0;
        bit  fin = 0;
        for (int i = 0; i < 4; i++) step(0, 8'h00, 8'h00, 0, 0, 0);
        step(1, 8'h00, 8'h03, 0, 0, 0);
        step(0, 8'h00, 8'h00, 1, 0, 0);
        checks++;
        if (obs !== {16'h0003, 3'b100}) begin
            errors++;
            $display("FAIL basic_start got=%h exp=%h", obs, {16'h0003, 3'b100});
        end
        for (int i = 0; i < 120 && !fin; i++) begin
            step(0, 8'h00, 8'h00, 0, 0, (i % 8) < 4);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL basic cyc=%0d got=%h exp=%h",
                         cyc, obs, exp_vec());
            end
            if (done) dones++;
            if (i > 40 && m_state == ST_IDLE) fin = 1;
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL basic_timeout got=busy exp=idle");
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL basic_done_count got=%0d exp=1", dones);
        end
        checks++;
        if (obs !== 19'd0) begin
            errors++;
            $display("FAIL basic_end got=%h exp=%h", obs, 19'd0);
        end
    endtask

    task automatic test_borrow();
        step(1, 8'h10, 8'h00, 0, 0, 0);
        step(0, 8'h00, 8'h00, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 8'h00, 8'h00, 0, 0, i < 4);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL borrow10 cyc=%0d got=%h exp=%h",
                         cyc, obs, exp_vec());
            end
        end
        checks++;
        if (obs[18:3] !== 16'h0959) begin
            errors++;
            $display("FAIL borrow10_val got=%h exp=0959", obs[18:3]);
        end
        step(0, 8'h00, 8'h00, 0, 1, 0);
        step(1, 8'h01, 8'h00, 0, 0, 0);
        step(0, 8'h00, 8'h00, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 8'h00, 8'h00, 0, 0, i < 4);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL borrow01 cyc=%0d got=%h exp=%h",
                         cyc, obs, exp_vec());
            end
        end
        checks++;
        if (obs !== {16'h0059, 3'b100}) begin
            errors++;
            $display("FAIL borrow01_val got=%h exp=%h", obs, {16'h0059, 3'b100});
        end
    endtask

    task automatic test_pause();
        step(0, 8'h00, 8'h00, 0, 1, 0);
        step(1, 8'h00, 8'h10, 0, 0, 0);
        step(0, 8'h00, 8'h00, 1, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 8'h00, 0, 0, (i % 8) < 4);
        step(0, 8'h00, 8'h00, 0, 1, 0);
        for (int i = 0; i < 24; i++) begin
            step(0, 8'h00, 8'h00, 0, 0, (i % 8) < 4);
            checks++;
            if (obs !== {16'h0008, 3'b000}) begin
                errors++;
                $display("FAIL pause_hold got=%h exp=%h", obs, {16'h0008, 3'b000});
            end
        end
        step(0, 8'h00, 8'h00, 1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 8'h00, 0, 0, i < 4);
        checks++;
        if (obs !== {16'h0007, 3'b100} || obs !== exp_vec()) begin
            errors++;
            $display("FAIL pause_resume got=%h exp=%h", obs, {16'h0007, 3'b100});
        end
    endtask

    task automatic test_edges();
        step(0, 8'h00, 8'h00, 0, 1, 0);
        step(1, 8'h00, 8'h00, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 8'h00, i == 0, 0, 0);
            checks++;
            if (obs !== 19'd0) begin
                errors++;
                $display("FAIL zero_start got=%h exp=%h", obs, 19'd0);
            end
        end
        step(1, 8'hAB, 8'h6C, 0, 0, 0);
        checks++;
        if (obs !== {16'h9959, 3'b000}) begin
            errors++;
            $display("FAIL sat_load got=%h exp=%h", obs, {16'h9959, 3'b000});
        end
        step(0, 8'h00, 8'h00, 1, 0, 0);
        step(0, 8'h00, 8'h00, 0, 1, 0);
        step(1, 8'h00, 8'h42, 1, 0, 0);
        checks++;
        if (obs !== {16'h0042, 3'b000} || obs !== exp_vec()) begin
            errors++;
            $display("FAIL pause_load_start got=%h exp=%h",
                     obs, {16'h0042, 3'b000});
        end
    endtask

    task automatic test_random();
        bit hzv = 0;
        int hc = 3;
        for (int i = 0; i < 4000; i++) begin
            bit ld = ($urandom % 60) == 0;
            logic [7:0] lm = (($urandom % 8) == 0) ? 8'h01 : 8'h00;
            logic [7:0] ls = {4'($urandom % 2), 4'($urandom % 10)};
            bit st = ($urandom % 8) == 0;
            bit pa = ($urandom % 25) == 0;
            if (hc == 0) begin
                hzv = ~hzv;
                hc = $urandom_range(2, 6);
            end
            hc--;
            step(ld, lm, ls, st, pa, hzv);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h",
                         cyc, obs, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) step(0, 8'h00, 8'h00, 0, 1, 0);
        step(1, 8'h00, 8'h05, 0, 0, 0);
        step(0, 8'h00, 8'h00, 1, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 8'h00, 0, 0, (i % 8) < 4);
        checks++;
        if (obs !== {16'h0003, 3'b100} || obs !== exp_vec()) begin
            errors++;
            $display("FAIL async_pre got=%h exp=%h", obs, {16'h0003, 3'b100});
        end
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs !== 19'd0) begin
            errors++;
            $display("FAIL async_now got=%h exp=%h", obs, 19'd0);
        end
        for (int i = 0; i < 2; i++) step(0, 8'h00, 8'h00, 0, 0, 0);
        reset = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step(0, 8'h00, 8'h00, 0, 0, (i % 8) < 4);
            checks++;
            if (obs !== exp_vec() || done !== 1'b0) begin
                errors++;
                $display("FAIL async_after cyc=%0d got=%h exp=%h",
                         cyc, obs, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_borrow();
        test_pause();
        test_edges();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
